// File: rtl/ioport_fifo_peripheral.sv
// ioport_fifo_peripheral: 8088 I/O-mapped slave with a TX FIFO and an RX holding register
module ioport_fifo_peripheral #(
  parameter logic [15:0] BASE_ADDR = 16'h0060,
  parameter int          DEPTH     = 8,
  parameter logic        IO_SPACE  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ALE,
  input  logic       IOM,
  input  logic       RD,
  input  logic       WR,
  input  logic       DEN,
  input  logic [11:0] A,
  input  logic [7:0] AD,
  output logic [7:0] DOUT,
  output logic       OE,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, READ, WRITE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          iom_q, iom_d, oe_q, oe_d, rx_full_q, rx_full_d, ovf_q, ovf_d;
  logic [7:0]    dout_q, dout_d, wdata_q, wdata_d, rx_hold_q, rx_hold_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          hit, sel, full, empty, pop, rd_done, wr_done, push_req, push, flush;
  logic [7:0]    status;
  logic          unused_addr;

  assign unused_addr = ^A[11:8];
  assign hit      = (iom_q == IO_SPACE) && (addr_q[15:1] == BASE_ADDR[15:1]);
  assign sel      = addr_q[0];
  assign full     = count_q == 5'(DEPTH);
  assign empty    = count_q == 5'd0;
  assign status   = {ovf_q, rx_full_q, full, empty, count_q[3:0]};
  assign pop      = !empty && tx_ready;
  assign push_req = wr_done && !sel;
  assign push     = push_req && (!full || pop);
  assign flush    = wr_done && sel && wdata_q[7];

  // bus cycle sequencing; a fresh ALE always restarts the cycle with no side effect
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iom_d   = iom_q;
    dout_d  = dout_q;
    oe_d    = 1'b0;
    wdata_d = wdata_q;
    rd_done = 1'b0;
    wr_done = 1'b0;
    if (ALE) begin
      state_d = ADDR;
      addr_d  = {A[7:0], AD};
      iom_d   = IOM;
    end else begin
      case (state_q)
        ADDR: state_d = !hit ? IDLE : !RD ? READ : !WR ? WRITE : ADDR;
        READ: begin
          dout_d  = sel ? status : rx_hold_q;
          oe_d    = !RD && !DEN;
          rd_done = RD;
          state_d = RD ? IDLE : READ;
        end
        WRITE: begin
          wdata_d = WR ? wdata_q : AD;
          wr_done = WR;
          state_d = WR ? IDLE : WRITE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // TX FIFO, overflow flag and RX holding register updates
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wdata_q;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d   = flush ? 5'd0 : count_q + 5'(push) - 5'(pop);
    ovf_d     = (rd_done && sel) ? 1'b0 : ovf_q || (push_req && full && !pop);
    rx_full_d = rx_full_q ? !(rd_done && !sel) : rx_valid;
    rx_hold_d = (!rx_full_q && rx_valid) ? rx_data : rx_hold_q;
  end

  // control state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      iom_q     <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      wdata_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_full_q <= 1'b0;
      rx_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iom_q     <= iom_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      wdata_q   <= wdata_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_full_q <= rx_full_d;
      rx_hold_q <= rx_hold_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count and pointers
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign DOUT     = dout_q;
  assign OE       = oe_q;
  assign tx_data  = mem_q[rd_ptr_q];
  assign tx_valid = !empty;
  assign rx_ready = !rx_full_q;
endmodule

// File: tb/tb_ioport_fifo_peripheral.sv
// tb_ioport_fifo_peripheral: randomized bench with a queue-based model of the I/O port peripheral
module tb_ioport_fifo_peripheral;
  localparam int          DEPTH = 8;
  localparam logic [15:0] BASE  = 16'h0060;

  logic       CLK = 1'b0, RESET = 1'b0, ALE = 1'b0, IOM = 1'b0;
  logic       RD = 1'b1, WR = 1'b1, DEN = 1'b1, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [11:0] A = '0;
  logic [7:0] AD = '0, rx_data = '0;
  logic [7:0] DOUT, tx_data;
  logic       OE, tx_valid, rx_ready;

  int         n_chk = 0, n_pass = 0;
  logic [7:0] mq[$];
  bit         m_rx_full, m_ovf, exp_oe, rand_en, m_pop, m_full, m_load;
  logic [7:0] m_rx_hold = '0;
  int         ev_kind = 0;
  bit         ev_sel;
  logic [7:0] ev_data;
  logic [7:0] got;
  logic [7:0] seen[$];

  ioport_fifo_peripheral #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .IO_SPACE(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR), .DEN(DEN),
    .A(A), .AD(AD), .DOUT(DOUT), .OE(OE), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovf, m_rx_full, mq.size() == DEPTH, mq.size() == 0, 4'(mq.size())};
  endfunction

  function automatic bit is_hit(input logic [15:0] addr, input logic iom);
    return iom && ((addr >> 1) == (BASE >> 1));
  endfunction

  // transaction-level model: FIFO as a queue, flags as bits, bus effects posted by the driver tasks
  always @(posedge CLK) begin
    if (!RESET) begin
      mq.delete();
      m_rx_full = 1'b0;
      m_ovf     = 1'b0;
      m_rx_hold = '0;
    end else begin
      m_pop  = mq.size() != 0 && tx_ready;
      m_full = mq.size() == DEPTH;
      m_load = !m_rx_full && rx_valid;
      if (m_pop) void'(mq.pop_front());
      if (ev_kind == 1 && !ev_sel) begin
        if (!m_full || m_pop) mq.push_back(ev_data);
        else m_ovf = 1'b1;
      end
      if (ev_kind == 1 && ev_sel && ev_data[7]) mq.delete();
      if (ev_kind == 2 && ev_sel) m_ovf = 1'b0;
      if (m_load) begin
        m_rx_full = 1'b1;
        m_rx_hold = rx_data;
      end else if (ev_kind == 2 && !ev_sel) m_rx_full = 1'b0;
    end
  end

  // every-cycle comparison of the streaming outputs and OE against the model
  always @(posedge CLK) begin
    #1;
    chk("tx_valid", 8'(tx_valid), 8'(mq.size() != 0));
    if (mq.size() != 0) chk("tx_data", tx_data, mq[0]);
    chk("rx_ready", 8'(rx_ready), 8'(!m_rx_full));
    chk("oe", 8'(OE), 8'(exp_oe));
  end

  // random local producer/consumer activity during the random phase
  always @(negedge CLK) begin
    if (rand_en) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = $urandom_range(0, 3) == 0;
      rx_data  = 8'($urandom);
    end
  end

  task automatic bus_addr(input logic [15:0] addr, input logic iom);
    @(negedge CLK);
    ALE = 1'b1; A = {4'h0, addr[15:8]}; AD = addr[7:0]; IOM = iom;
    @(negedge CLK);
    ALE = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic iom, input int nlow, output logic [7:0] val);
    bit h;
    logic [7:0] e;
    h = is_hit(addr, iom);
    bus_addr(addr, iom);
    RD = 1'b0; DEN = 1'b0;
    @(negedge CLK);
    e = addr[0] ? m_status() : m_rx_hold;
    exp_oe = h;
    @(negedge CLK);
    val = DOUT;
    if (h) chk("dout", DOUT, e);
    repeat (nlow - 2) @(negedge CLK);
    RD = 1'b1; DEN = 1'b1; exp_oe = 1'b0;
    if (h) begin ev_kind = 2; ev_sel = addr[0]; end
    @(negedge CLK);
    ev_kind = 0;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic iom, input logic [7:0] data, input bit pop_at_done);
    bit h;
    h = is_hit(addr, iom);
    bus_addr(addr, iom);
    WR = 1'b0; AD = data;
    @(negedge CLK);
    @(negedge CLK);
    WR = 1'b1;
    if (h) begin ev_kind = 1; ev_sel = addr[0]; ev_data = data; end
    if (pop_at_done) tx_ready = 1'b1;
    @(negedge CLK);
    ev_kind = 0;
    if (pop_at_done) tx_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_oe", 8'(OE), 8'h00);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_rx_ready", 8'(rx_ready), 8'h01);
    RESET = 1'b1;
    cpu_read(16'h0061, 1'b1, 3, got);
    chk("status_reset", got, 8'h10);
    cpu_write(16'h0060, 1'b1, 8'hA5, 1'b0);
    chk("tx_valid_a5", 8'(tx_valid), 8'h01);
    chk("tx_data_a5", tx_data, 8'hA5);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_one", got, 8'h01);
    cpu_write(16'h0061, 1'b1, 8'h80, 1'b0);
    chk("flush_empty", 8'(tx_valid), 8'h00);
    for (int i = 1; i <= 8; i++) cpu_write(16'h0060, 1'b1, 8'(i), 1'b0);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_full", got, 8'h28);
    cpu_write(16'h0060, 1'b1, 8'h09, 1'b0);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_ovf", got, 8'hA8);
    tx_ready = 1'b1;
    seen.delete();
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) seen.push_back(tx_data);
      @(negedge CLK);
    end
    tx_ready = 1'b0;
    chk("drain_count", 8'(seen.size()), 8'h08);
    for (int i = 0; i < seen.size() && i < 8; i++) chk("drain_order", seen[i], 8'(i + 1));
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_ovf_cleared", got, 8'h10);
    rx_valid = 1'b1; rx_data = 8'h3C;
    @(negedge CLK);
    rx_data = 8'h3D;
    chk("rx_ready_full", 8'(rx_ready), 8'h00);
    cpu_read(16'h0060, 1'b1, 3, got);
    chk("rx_3c", got, 8'h3C);
    chk("rx_ready_cleared", 8'(rx_ready), 8'h01);
    @(negedge CLK);
    rx_valid = 1'b0;
    chk("rx_reloaded", 8'(rx_ready), 8'h00);
    cpu_read(16'h0060, 1'b1, 2, got);
    chk("rx_3d", got, 8'h3D);
    for (int i = 0; i < 5; i++) cpu_write(16'h0060, 1'b1, 8'(8'h40 + i), 1'b0);
    cpu_write(16'h0062, 1'b1, 8'h77, 1'b0);
    cpu_write(16'h0060, 1'b0, 8'h55, 1'b0);
    cpu_read(16'h0062, 1'b1, 2, got);
    cpu_read(16'h0060, 1'b0, 2, got);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_miss", got, 8'h05);
    chk("head_after_miss", tx_data, 8'h40);
    cpu_write(16'h0061, 1'b1, 8'h80, 1'b0);
    chk("flush_five", 8'(tx_valid), 8'h00);
    rx_valid = 1'b1; rx_data = 8'h5A;
    cpu_write(16'h0060, 1'b1, 8'h01, 1'b0);
    rx_valid = 1'b0;
    bus_addr(16'h0060, 1'b1);
    WR = 1'b0; AD = 8'hEE;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_dout", DOUT, 8'h00);
    chk("midrst_oe", 8'(OE), 8'h00);
    chk("midrst_tx_valid", 8'(tx_valid), 8'h00);
    chk("midrst_rx_ready", 8'(rx_ready), 8'h01);
    RESET = 1'b1; WR = 1'b1;
    @(negedge CLK);
    chk("midrst_no_push", 8'(tx_valid), 8'h00);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("status_after_rst", got, 8'h10);
    for (int i = 0; i < 8; i++) cpu_write(16'h0060, 1'b1, 8'(8'h11 + i), 1'b0);
    cpu_write(16'h0060, 1'b1, 8'h99, 1'b1);
    chk("full_pushpop_head", tx_data, 8'h12);
    cpu_read(16'h0061, 1'b1, 2, got);
    chk("full_pushpop_status", got, 8'h28);
    cpu_write(16'h0061, 1'b1, 8'h80, 1'b0);
    rand_en = 1'b1;
    repeat (300) begin
      case ($urandom_range(0, 5))
        0, 1: cpu_write(16'h0060, 1'b1, 8'($urandom), 1'b0);
        2: cpu_write(16'h0061, 1'b1, {$urandom_range(0, 7) == 0, 7'($urandom)}, 1'b0);
        3: cpu_read(16'h0060, 1'b1, $urandom_range(2, 4), got);
        4: cpu_read(16'h0061, 1'b1, $urandom_range(2, 4), got);
        default: begin
          case ($urandom_range(0, 3))
            0: cpu_write(16'h0062, 1'b1, 8'($urandom), 1'b0);
            1: cpu_read(16'h0063, 1'b1, 2, got);
            2: cpu_write(16'h005F, 1'b1, 8'($urandom), 1'b0);
            default: cpu_write(16'h0060, 1'b0, 8'($urandom), 1'b0);
          endcase
        end
      endcase
    end
    rand_en = 1'b0;
    @(negedge CLK);
    tx_ready = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ioport_fifo_peripheral.md
Name: ioport_fifo_peripheral

Overview:
- I/O-mapped 8088 bus slave, directly downstream of the Intel8088Pins bus.
- Latches the multiplexed address on ALE and decodes a two-byte port window.
- Services RD/WR strobes and drives OE to enable the data transceiver.
- CPU writes to the data port are buffered in a TX FIFO drained by a local consumer. CPU reads of the data port return a single-byte RX holding register filled by a local producer.

Parameters:
BASE_ADDR, 16'h0060, data port address; BASE_ADDR+1 is the status/control port; bit 0 must be 0
DEPTH, 8, TX FIFO depth; power of 2, 2..16
IO_SPACE, 1, value of IOM that selects this peripheral (1 = I/O cycle)

Ports:
CLK  input  1  bus clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset
ALE  input  1  address latch enable, active-high
IOM  input  1  I/O-vs-memory qualifier
RD  input  1  read strobe, active-low
WR  input  1  write strobe, active-low
DEN  input  1  data enable, active-low
A  input  12  address bits [19:8]
AD  input  8  multiplexed address [7:0] / write data
DOUT  output  8  read data, driven onto AD externally when OE=1
OE  output  1  read-data output enable, active-high
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO not empty
tx_ready  input  1  consumer accepts head byte
rx_data  input  8  producer byte
rx_valid  input  1  producer byte valid
rx_ready  output  1  holding register empty

Behaviour:
- Reset (RESET=0 at a clock edge):
  - state IDLE; OE=0, DOUT=0, count=0, pointers=0, rx_full=0, ovf=0.
  - rx_ready=1, tx_valid=0.
  - Any bus cycle in progress is aborted with no push, pop or flag clear.
- Address latch: on any edge with ALE=1, capture addr_q={A[15:8],AD}, iom_q=IOM, then go to ADDR. This applies from every state, including READ and WRITE (a new ALE aborts the old cycle with no side effect).
- hit = (iom_q==IO_SPACE) && (addr_q[15:1]==BASE_ADDR[15:1]); sel = addr_q[0].
- States:
  - IDLE: wait for ALE.
  - ADDR:
    - !hit -> IDLE.
    - hit && RD==0 -> READ.
    - hit && WR==0 -> WRITE.
    - Otherwise hold.
  - READ:
    - DOUT = (sel==0) ? rx_hold : status, registered every cycle.
    - OE=1 while RD==0 && DEN==0, registered; OE therefore trails DEN/RD by one cycle.
    - When RD is sampled 1: OE=0, apply read side effect, go to IDLE.
    - Side effect on sel==0: clear rx_full.
    - Side effect on sel==1: clear ovf.
  - WRITE:
    - wdata_q=AD on every edge with WR==0.
    - When WR is sampled 1, apply the write effect and go to IDLE.
    - sel==0: push wdata_q if FIFO not full; otherwise set ovf and drop the byte.
    - sel==1: if wdata_q[7]==1, flush the FIFO (pointers and count to 0); other bits ignored.
- Status byte: {ovf, rx_full, fifo_full, fifo_empty, count[3:0]}. count saturates at DEPTH; fifo_full = (count==DEPTH).
- FIFO:
  - Circular, log2(DEPTH)-bit pointers wrap modulo DEPTH.
  - pop = tx_valid && tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A push while full is accepted if a pop occurs the same cycle.
  - Flush overrides a simultaneous push or pop.
- RX holding register:
  - rx_ready = !rx_full.
  - rx_valid && rx_ready loads rx_hold and sets rx_full.
  - A CPU read clearing rx_full in the same cycle as rx_valid does not load; the load happens on the next cycle.
- Reads of sel==0 with rx_full==0 return the stale rx_hold and still complete normally.
- Latency: write data is visible on tx_data 1 cycle after the WR-deassert edge (when the FIFO was empty). Read data is valid on DOUT 1 cycle after READ entry.

Test Plan:
- Reset then ALE with A=0, AD=8'h61, IOM=1; RD low 3 cycles -> OE=1, DOUT=8'h10 (empty, count 0); RD high -> OE=0, state IDLE.
- Write 8'hA5 to 0x0060, tx_ready=0 -> tx_valid=1, tx_data=8'hA5; status read -> 8'h01.
- 9 writes (bytes 1..9) with tx_ready=0 -> after 8, status=8'h28; 9th sets ovf (status 8'hA8); drain with tx_ready=1 -> bytes 1..8 in order, pointers wrap; second status read shows ovf=0.
- rx_valid=1, rx_data=8'h3C -> rx_ready drops; CPU read of 0x0060 -> DOUT=8'h3C; after RD high, rx_ready=1, next byte 8'h3D loads one cycle later.
- Address 0x0062, or IOM=0 with 0x0060 -> no OE, no push, FIFO/flags unchanged; write 8'h80 to 0x0061 with 5 queued -> count 0, tx_valid=0.
- RESET=0 mid-WRITE (WR low) -> no push, all outputs at reset values next cycle; full FIFO with simultaneous CPU push and tx_ready=1 -> count stays DEPTH, no ovf.
